// File: rtl/decode_imm_stage_pkg.sv
// Shared types and constants for the decode immediate stage.
// Immediate formats, RV32I opcodes, buffer states, opcode classifier.
package decode_imm_stage_pkg;

    typedef enum logic [2:0] {
        ITYPE = 3'd0,
        STYPE = 3'd1,
        BTYPE = 3'd2,
        UTYPE = 3'd3,
        JTYPE = 3'd4,
        NTYPE = 3'd5,
        RTYPE = 3'd6,
        RSVD  = 3'd7
    } imm_type_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } buf_state_e;

    // Full 7-bit match; anything unlisted is NTYPE (illegal).
    function automatic imm_type_e classify(input logic [6:0] op);
        imm_type_e t;
        t = NTYPE;
        case (op)
            OP_LUI, OP_AUIPC: t = UTYPE;
            OP_JAL:           t = JTYPE;
            OP_JALR, OP_LOAD, OP_IMM,
            OP_FENCE, OP_SYSTEM: t = ITYPE;
            OP_STORE:         t = STYPE;
            OP_BRANCH:        t = BTYPE;
            OP_OP:            t = RTYPE;
            default:          t = NTYPE;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/decode_imm_stage_imm_ext.sv
// IMM_EXT: builds the sign-extended RV32I immediate from INS[31:7].
// IN_BITS = INS[31:7], IN_TYPE = format, OUT_IMM = 32-bit immediate.
module IMM_EXT
    import decode_imm_stage_pkg::*;
(
    input  logic [24:0] IN_BITS,
    input  logic [2:0]  IN_TYPE,
    output logic [31:0] OUT_IMM
);

    // b[k] holds instruction bit k+7.
    logic [24:0] b;
    imm_type_e   t;

    assign b = IN_BITS;
    assign t = imm_type_e'(IN_TYPE);

    always_comb begin
        OUT_IMM = 32'd0;
        case (t)
            ITYPE: OUT_IMM = {{20{b[24]}}, b[24:13]};
            STYPE: OUT_IMM = {{20{b[24]}}, b[24:18], b[4:0]};
            BTYPE: OUT_IMM = {{19{b[24]}}, b[24], b[0],
                              b[23:18], b[4:1], 1'b0};
            UTYPE: OUT_IMM = {b[24:5], 12'd0};
            JTYPE: OUT_IMM = {{11{b[24]}}, b[24], b[12:5],
                              b[13], b[23:14], 1'b0};
            default: OUT_IMM = 32'd0;
        endcase
    end

endmodule

// File: rtl/decode_imm_stage.sv
// Decode front end: classifies opcode, extends immediate, 2-entry skid.
// Ports: CLK/RST/FLUSH; IN_* fetch handshake; OUT_* execute handshake.
module decode_imm_stage
    import decode_imm_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  FLUSH,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [31:0]           IN_INS,
    input  logic [ADDR_WIDTH-1:0] IN_PC,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [31:0]           OUT_INS,
    output logic [ADDR_WIDTH-1:0] OUT_PC,
    output logic [2:0]            OUT_TYPE,
    output logic [31:0]           OUT_IMM,
    output logic                  OUT_ILLEGAL
);

    buf_state_e state_q;

    logic [31:0]           main_ins_q, skid_ins_q;
    logic [ADDR_WIDTH-1:0] main_pc_q,  skid_pc_q;
    logic [2:0]            main_type_q, skid_type_q;
    logic [31:0]           main_imm_q, skid_imm_q;
    logic                  main_ill_q, skid_ill_q;

    imm_type_e   type_d;
    logic [31:0] imm_d;
    logic        ill_d;
    logic        accept;
    logic        drain;

    assign type_d = classify(IN_INS[6:0]);
    assign ill_d  = (type_d == NTYPE);

    IMM_EXT u_imm_ext (
        .IN_BITS (IN_INS[31:7]),
        .IN_TYPE (type_d),
        .OUT_IMM (imm_d)
    );

    // Ready depends only on state (and reset), never on OUT_READY.
    assign IN_READY  = ~RST & (state_q != S_FULL);
    assign OUT_VALID = (state_q != S_EMPTY);
    assign accept    = IN_VALID & IN_READY;
    assign drain     = OUT_VALID & OUT_READY;

    assign OUT_INS     = main_ins_q;
    assign OUT_PC      = main_pc_q;
    assign OUT_TYPE    = main_type_q;
    assign OUT_IMM     = main_imm_q;
    assign OUT_ILLEGAL = main_ill_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_EMPTY;
            main_ins_q  <= 32'd0;
            main_pc_q   <= '0;
            main_type_q <= NTYPE;
            main_imm_q  <= 32'd0;
            main_ill_q  <= 1'b0;
            skid_ins_q  <= 32'd0;
            skid_pc_q   <= '0;
            skid_type_q <= NTYPE;
            skid_imm_q  <= 32'd0;
            skid_ill_q  <= 1'b0;
        end else if (FLUSH) begin
            // Data regs keep last values; only validity is dropped.
            state_q <= S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        state_q     <= S_ONE;
                        main_ins_q  <= IN_INS;
                        main_pc_q   <= IN_PC;
                        main_type_q <= type_d;
                        main_imm_q  <= imm_d;
                        main_ill_q  <= ill_d;
                    end
                end
                S_ONE: begin
                    if (accept && drain) begin
                        main_ins_q  <= IN_INS;
                        main_pc_q   <= IN_PC;
                        main_type_q <= type_d;
                        main_imm_q  <= imm_d;
                        main_ill_q  <= ill_d;
                    end else if (accept) begin
                        state_q     <= S_FULL;
                        skid_ins_q  <= IN_INS;
                        skid_pc_q   <= IN_PC;
                        skid_type_q <= type_d;
                        skid_imm_q  <= imm_d;
                        skid_ill_q  <= ill_d;
                    end else if (drain) begin
                        state_q <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (drain) begin
                        state_q     <= S_ONE;
                        main_ins_q  <= skid_ins_q;
                        main_pc_q   <= skid_pc_q;
                        main_type_q <= skid_type_q;
                        main_imm_q  <= skid_imm_q;
                        main_ill_q  <= skid_ill_q;
                    end
                end
                default: state_q <= S_EMPTY;
            endcase
        end
    end

endmodule
